counter_scheduler: RTL and testbench

- Round-robin scheduler that time-shares one `Counter` instance between `NUM_REQ` requesters.
- Each requester asks for a number of full counter laps. The scheduler grants one requester at a time and drives the counter's `enb`.
- It counts `carryout` events and signals per-requester completion.
- It sits beside the `Counter` in the simulation top and replaces the fixed test-scenario FSM as the counter's only enable source.

---
 rtl/counter_scheduler.sv | 127 ++++++++++++
 tb/tb_counter_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Round-robin scheduler that time-shares one Counter between NUM_REQ requesters.
// Each granted requester owns the counter's enable until it has seen its
// requested number of carryout laps, or until it withdraws its request.
module counter_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LAP_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LAP_W-1:0] laps,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     aborted,
    output logic                     busy,
    output logic [LAP_W-1:0]         lap_count,
    output logic                     cnt_enb,
    input  logic                     cnt_carryout
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   sel_q, sel_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [LAP_W-1:0]  target_q, target_d;
    logic [LAP_W-1:0]  lap_q, lap_d;
    logic              aborted_q, aborted_d;

    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cand;
    logic [LAP_W-1:0]  pick_laps;
    logic [LAP_W-1:0]  lap_inc;
    logic [NUM_REQ-1:0] sel_onehot;

    // Search for the first asserted request starting at the round-robin pointer
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = IdxW'((32'(ptr_q) + 32'(i)) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_laps = laps[32'(pick_idx) * LAP_W +: LAP_W];
        lap_inc   = lap_q + LAP_W'(1);
    end

    // Next-state logic: arbitrate in IDLE, count laps in RUN, one-cycle DONE
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        target_d  = target_q;
        lap_d     = lap_q;
        aborted_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    sel_d    = pick_idx;
                    ptr_d    = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
                    // A zero-lap request is run as a single lap
                    target_d = (pick_laps == '0) ? LAP_W'(1) : pick_laps;
                    lap_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (cnt_carryout) begin
                    lap_d = lap_inc;
                end
                // Completion wins over a withdrawal seen in the same cycle
                if (cnt_carryout && (lap_inc == target_q)) begin
                    state_d   = StDone;
                    aborted_d = 1'b0;
                end else if (!req[sel_q]) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and job registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            ptr_q     <= '0;
            target_q  <= '0;
            lap_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            target_q  <= target_d;
            lap_q     <= lap_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs decoded from state so reset clears them without waiting for a clock
    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
        gnt               = (state_q == StRun)  ? sel_onehot : '0;
        done              = (state_q == StDone) ? sel_onehot : '0;
        cnt_enb           = (state_q == StRun);
        busy              = (state_q != StIdle);
        aborted           = aborted_q;
        lap_count         = lap_q;
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler with a 4-bit counter model beside it.
module tb_counter_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] laps;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        aborted;
    logic        busy;
    logic [3:0]  lap_count;
    logic        cnt_enb;
    logic        carryout;
    logic [3:0]  cnt;

    int tests = 0;
    int fails = 0;

    int         pre, enb, co, gb, n;
    logic [3:0] dn, lc;
    logic       ab;
    bit         to;

    counter_scheduler #(
        .NUM_REQ(4),
        .LAP_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .laps        (laps),
        .gnt         (gnt),
        .done        (done),
        .aborted     (aborted),
        .busy        (busy),
        .lap_count   (lap_count),
        .cnt_enb     (cnt_enb),
        .cnt_carryout(carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit Counter model: carryout is combinational at all-ones with enb high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (cnt_enb) cnt <= cnt + 4'd1;
    end
    assign carryout = cnt_enb && (cnt == 4'hF);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run until done pulses; drop the granted request at enb cycle drop_at (0 = never)
    task automatic run_job(input logic [3:0] exp_gnt, input int drop_at);
        pre = 0; enb = 0; co = 0; gb = 0; dn = '0; ab = 1'b0; lc = '0; to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done != 4'b0) begin
                dn = done; ab = aborted; lc = lap_count; to = 1'b0;
                break;
            end
            if (cnt_enb) begin
                enb++;
                if (gnt !== exp_gnt) gb++;
                if (carryout) co++;
                if (enb == drop_at) req = req & ~exp_gnt;
            end else if (enb == 0) begin
                pre++;
            end
        end
    endtask

    task automatic check_job(input string tag, input logic [3:0] exp_done, input logic exp_ab,
                             input logic [3:0] exp_lc, input int exp_enb);
        check({tag, " timeout"}, 32'(to), 32'd0);
        check({tag, " gnt"}, gb, 0);
        check({tag, " done"}, 32'(dn), 32'(exp_done));
        check({tag, " aborted"}, 32'(ab), 32'(exp_ab));
        check({tag, " lap_count"}, 32'(lc), 32'(exp_lc));
        check({tag, " enb_cycles"}, enb, exp_enb);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0;
        laps  = 16'h0;
        tick();
        tick();
        check("rst gnt", 32'(gnt), 0);
        check("rst done", 32'(done), 0);
        check("rst aborted", 32'(aborted), 0);
        check("rst busy", 32'(busy), 0);
        check("rst lap_count", 32'(lap_count), 0);
        check("rst cnt_enb", 32'(cnt_enb), 0);
        rst_n = 1'b1;

        // Round-robin over all four with one lap each: 0,1,2,3,0
        req  = 4'b1111;
        laps = 16'h1111;
        run_job(4'b0001, 0);
        check("rr0 pre", pre, 0);
        check_job("rr0", 4'b0001, 1'b0, 4'd1, 16);
        run_job(4'b0010, 0);
        check("rr1 pre", pre, 1);
        check_job("rr1", 4'b0010, 1'b0, 4'd1, 16);
        run_job(4'b0100, 0);
        check_job("rr2", 4'b0100, 1'b0, 4'd1, 16);
        run_job(4'b1000, 0);
        check_job("rr3", 4'b1000, 1'b0, 4'd1, 16);
        run_job(4'b0001, 0);
        check("rr4 pre", pre, 1);
        check_job("rr4", 4'b0001, 1'b0, 4'd1, 16);
        req = 4'b0;
        tick();
        check("done one cycle", 32'(done), 0);
        check("aborted cleared", 32'(aborted), 0);
        check("idle busy", 32'(busy), 0);
        check("lap_count held", 32'(lap_count), 1);

        // Single two-lap job for requester 0, counter at 0
        req  = 4'b0001;
        laps = 16'h0002;
        run_job(4'b0001, 0);
        check("single pre", pre, 0);
        check("single carryouts", co, 2);
        check_job("single", 4'b0001, 1'b0, 4'd2, 32);
        req = 4'b0;
        tick();

        // Pointer fairness: grant 2, then with 0101 grant 0, then 2
        req  = 4'b0100;
        laps = 16'h1111;
        run_job(4'b0100, 0);
        check_job("fair2", 4'b0100, 1'b0, 4'd1, 16);
        req = 4'b0101;
        run_job(4'b0001, 0);
        check_job("fair0", 4'b0001, 1'b0, 4'd1, 16);
        req = 4'b0100;
        run_job(4'b0100, 0);
        check_job("fair2b", 4'b0100, 1'b0, 4'd1, 16);
        req = 4'b0;
        tick();

        // Abort: three laps requested, withdrawn after 20 enb cycles
        req  = 4'b0010;
        laps = 16'h0030;
        run_job(4'b0010, 20);
        check_job("abort", 4'b0010, 1'b1, 4'd1, 20);
        tick();
        check("abort aborted cleared", 32'(aborted), 0);

        // Next job starts from count 4, so its first lap is 12 cycles
        req  = 4'b0100;
        laps = 16'h0100;
        run_job(4'b0100, 0);
        check_job("partial", 4'b0100, 1'b0, 4'd1, 12);
        req = 4'b0;
        tick();

        // laps=0 runs one lap; withdrawal on the final carryout cycle still completes
        req  = 4'b1000;
        laps = 16'h0000;
        run_job(4'b1000, 16);
        check_job("simul", 4'b1000, 1'b0, 4'd1, 16);
        tick();

        // Reset in the middle of a job
        req  = 4'b0011;
        laps = 16'h1111;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cnt_enb) n++;
            if (n == 7) break;
        end
        check("pre-reset gnt", 32'(gnt), 32'b0001);
        rst_n = 1'b0;
        #1;
        check("midrst gnt", 32'(gnt), 0);
        check("midrst cnt_enb", 32'(cnt_enb), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst lap_count", 32'(lap_count), 0);
        tick();
        check("midrst done", 32'(done), 0);
        rst_n = 1'b1;
        run_job(4'b0001, 0);
        check("post-rst pre", pre, 0);
        check_job("post-rst", 4'b0001, 1'b0, 4'd1, 16);
        req = 4'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
